// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Single-outstanding data-memory responder with a
//                valid/ready request channel and a valid/ready response
//                channel. Supports byte/half/word loads and stores,
//                sign/zero extension and a fixed number of wait states.
//                Optional feature macro: DMEM_MISALIGN_TRAP_EN
//                  defined   -> misaligned accesses return rsp_err = 1,
//                               rsp_rdata = 0 and do not write storage
//                  undefined -> misaligned low address bits are cleared
//                               and the access proceeds normally
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         C_AW   = $clog2(DEPTH_WORDS);
    localparam int         C_LW   = C_AW + 2;
    localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [C_LW-1:0]   addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic              w_src_we;
    logic [C_LW-1:0]   w_src_addr;
    logic [31:0]       w_src_wdata;
    logic [1:0]        w_src_size;
    logic              w_src_uns;
    logic              w_mis;
    logic              w_err;
    logic [C_LW-1:0]   w_eff_addr;
    logic [C_AW-1:0]   w_idx;
    logic [31:0]       w_old_word;
    logic [31:0]       w_shift;
    logic [31:0]       w_load_data;
    logic [3:0]        w_be;
    logic [31:0]       w_wrep;
    logic [31:0]       w_new_word;
    logic              w_enter_resp;
    logic              w_mem_we;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:C_LW];

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // With zero wait states the access completes on the accept edge, so the
    // datapath must look at the live request; otherwise at the latched copy.
    assign w_src_we    = (state_q == IDLE) ? req_we            : we_q;
    assign w_src_addr  = (state_q == IDLE) ? req_addr[C_LW-1:0] : addr_q;
    assign w_src_wdata = (state_q == IDLE) ? req_wdata         : wdata_q;
    assign w_src_size  = (state_q == IDLE) ? req_size          : size_q;
    assign w_src_uns   = (state_q == IDLE) ? req_unsigned      : uns_q;

    assign w_mis = ((w_src_size == 2'b01) && w_src_addr[0]) ||
                   (w_src_size[1] && (w_src_addr[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_err      = w_mis;
    assign w_eff_addr = w_src_addr;
`else
    assign w_err = 1'b0;
    // Force natural alignment by dropping the offending low address bits.
    always_comb begin
        w_eff_addr = w_src_addr;
        if (w_mis) begin
            if (w_src_size == 2'b01) begin
                w_eff_addr[0] = 1'b0;
            end else begin
                w_eff_addr[1:0] = 2'b00;
            end
        end
    end
`endif

    assign w_idx      = w_eff_addr[C_LW-1:2];
    assign w_old_word = mem_q[w_idx];

    // Load path: move the selected lane down to bit 0, then extend.
    always_comb begin
        w_shift = w_old_word >> {w_eff_addr[1:0], 3'b000};
        case (w_src_size)
            2'b00:   w_load_data = w_src_uns ? {24'd0, w_shift[7:0]}
                                             : {{24{w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_load_data = w_src_uns ? {16'd0, w_shift[15:0]}
                                             : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_load_data = w_old_word;
        endcase
    end

    // Store path: replicate the store data into every lane and merge only
    // the enabled bytes over the current word contents.
    always_comb begin
        case (w_src_size)
            2'b00: begin
                w_be   = 4'b0001 << w_eff_addr[1:0];
                w_wrep = {4{w_src_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = w_eff_addr[1] ? 4'b1100 : 4'b0011;
                w_wrep = {2{w_src_wdata[15:0]}};
            end
            default: begin
                w_be   = 4'b1111;
                w_wrep = w_src_wdata;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            w_new_word[i*8 +: 8] = w_be[i] ? w_wrep[i*8 +: 8] : w_old_word[i*8 +: 8];
        end
    end

    // Next-state logic: accept, count wait states, hold response until taken.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        uns_d        = uns_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        w_enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr[C_LW-1:0];
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    if (C_WAIT == 4'd0) begin
                        state_d      = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        cnt_d   = C_WAIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d      = RESP;
                    w_enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (w_enter_resp) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = w_err;
            rsp_rdata_d = (w_src_we || w_err) ? 32'd0 : w_load_data;
        end
    end

    // Control and response registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Store commits on the edge entering RESP; reset suppresses the write.
    assign w_mem_we = w_enter_resp && w_src_we && !w_err && !reset;

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_idx] <= w_new_word;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Scoreboard bench for dmem_responder (WAIT_CYCLES = 2,
//                DEPTH_WORDS = 256) with a byte-array reference model.
//                Honours DMEM_MISALIGN_TRAP_EN in the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem_m [4*DEPTH];
    int         n_vec  = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference model: memory as a flat byte array, addresses wrap at 1 KiB.
    function automatic exp_t model(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [1:0] size,
                                   input logic uns);
        exp_t        e;
        int          a;
        int          n;
        logic [31:0] v;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        a = int'(addr[9:0]);
        e.rdata = 32'd0;
        e.err   = 1'b0;
        e.acc   = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((a % n) != 0) begin
            e.err = 1'b1;
            return e;
        end
`else
        a = a - (a % n);
`endif
        if (we) begin
            for (int k = 0; k < n; k++) mem_m[a+k] = wdata[8*k +: 8];
        end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = mem_m[a+k];
            if (!uns && n < 4 && v[8*n-1]) begin
                for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
            end
            e.rdata = v;
        end
        return e;
    endfunction

    // One complete transaction; hold = cycles rsp_ready stays low in RESP.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input int hold);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        rsp_ready    = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e     = model(we, addr, wdata, size, uns);
        e.acc = cyc;
        exp_q.push_back(e);
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        n = 0;
        while (!rsp_valid && n < 20) begin
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", 32'(rsp_valid), 32'd1);
            return;
        end
        repeat (hold) begin
            @(negedge clk);
            chk("req_ready_hold", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    // Start a word store and hit reset while it sits in the wait states.
    task automatic abort_store(input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = 2'b10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_rdata", rsp_rdata, 32'd0);
        chk("abort_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard on each new response, checks stability after.
    initial begin
        exp_t        e;
        logic [31:0] hd;
        logic        he;
        bit          seen;
        seen = 1'b0;
        hd   = 32'd0;
        he   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rsp_valid) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                hd   = rsp_rdata;
                he   = rsp_err;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rdata 0x%08h with empty scoreboard", rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("latency", 32'(cyc - e.acc), 32'(WAITC));
                end
            end else begin
                chk("hold_rdata", rsp_rdata, hd);
                chk("hold_err", 32'(rsp_err), 32'(he));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Stimulus: reset, fill memory, directed cases, then random traffic.
    initial begin
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_err", 32'(rsp_err), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(i * 4), $urandom, 2'b10, 1'b0, 0);

        xact(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0);
        xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0);

        xact(1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, 0);
        xact(1'b1, 32'h22, 32'h000000AA, 2'b00, 1'b0, 1);
        xact(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0);
        xact(1'b0, 32'h22, 32'h0, 2'b00, 1'b0, 0);
        xact(1'b0, 32'h22, 32'h0, 2'b00, 1'b1, 0);

        xact(1'b1, 32'h402, 32'h00008001, 2'b01, 1'b0, 0);
        xact(1'b0, 32'h002, 32'h0, 2'b01, 1'b0, 0);

        xact(1'b1, 32'h31, 32'h12345678, 2'b10, 1'b0, 0);
        xact(1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 0);

        xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5);
        abort_store(32'h40, 32'hCAFEF00D);
        xact(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 0);

        for (int i = 0; i < 300; i++) begin
            xact(1'($urandom), $urandom, $urandom, 2'($urandom_range(0, 3)),
                 1'($urandom), int'($urandom_range(0, 2)));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
